fetch_unit: RTL



---
 rtl/fetch_unit.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front-end.
// Issues reads to a 1-cycle synchronous ROM, captures the returned words in a
// small in-order buffer and hands them to decode. A redirect squashes the
// in-flight read and flushes the buffer.
// Optional build macro: FETCH_BOUNDS_CHECK_EN adds a fetch-window check
// that raises fetch_fault and parks the FSM in HALT until a redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0100_0000,
  parameter logic [31:0] MEM_BASE  = 32'h0100_0000,
  parameter int          MEM_WORDS = 1024,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic        imem_rd,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  input  logic        dec_ready,
  output logic        fetch_fault
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  // One extra bit so count + inflight never overflows.
  localparam int CW = $clog2(BUF_DEPTH + 1) + 1;

  if (BUF_DEPTH < 2) begin : g_depth_check
    $error("fetch_unit: BUF_DEPTH must be at least 2");
  end
  if (MEM_BASE[1:0] != 2'b00) begin : g_base_check
    $error("fetch_unit: MEM_BASE must be word aligned");
  end
  if (MEM_WORDS < 1) begin : g_words_check
    $error("fetch_unit: MEM_WORDS must be positive");
  end

  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

  // state_q is the FSM state visible to bound checkers.
  state_t         state_q, state_d;
  logic [31:0]    pc_q;
  logic           inflight_q;
  logic [31:0]    inflight_pc_q;
  logic [PW-1:0]  head_q, tail_q;
  logic [CW-1:0]  count_q;
  logic [31:0]    buf_instr [BUF_DEPTH];
  logic [31:0]    buf_pc    [BUF_DEPTH];

  logic           pop;
  logic           push;
  logic           space_ok;
  logic           in_range;
  logic [31:0]    target;
  logic [CW-1:0]  occupancy;

  // Decode handshake: the head entry transfers on a cycle where dec_valid=1
  // and dec_ready=1; dec_instr/dec_pc hold steady while dec_valid=1 and
  // dec_ready=0. Only a redirect or reset may withdraw dec_valid.
  assign pop       = dec_valid & dec_ready;
  assign push      = inflight_q & ~redirect_valid;
  assign target    = redirect_pc & ~32'h3;
  assign occupancy = count_q + CW'(inflight_q) - CW'(pop);
  assign space_ok  = occupancy < CW'(BUF_DEPTH);

  assign dec_valid = (count_q != '0);
  assign dec_instr = buf_instr[head_q];
  assign dec_pc    = buf_pc[head_q];

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam logic [32:0] WIN_LO = {1'b0, MEM_BASE};
  localparam logic [32:0] WIN_HI = {1'b0, MEM_BASE} + 33'(4 * MEM_WORDS);
  logic fault_q;

  assign in_range    = ({1'b0, pc_q} >= WIN_LO) && ({1'b0, pc_q} < WIN_HI);
  assign fetch_fault = fault_q;

  // Fault flag tracks entry into HALT; a redirect clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= (state_d == S_HALT);
  end
`else
  // No window check: upper address bits simply alias into the memory.
  assign in_range    = 1'b1;
  assign fetch_fault = 1'b0;
`endif

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RUN;
    else        state_q <= state_d;
  end

  // FSM next state: redirect always returns to RUN; an out-of-window fetch halts.
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = S_RUN;
    end else if (state_q == S_RUN && fetch_en && !in_range) begin
      state_d = S_HALT;
    end
  end

  // FSM outputs: read strobe and address; redirect bypasses the space check.
  always_comb begin
    imem_rd   = 1'b0;
    imem_addr = redirect_valid ? target : pc_q;
    if (rst_n) begin
      if (redirect_valid) imem_rd = fetch_en;
      else                imem_rd = (state_q == S_RUN) && fetch_en && space_ok && in_range;
    end
  end

  // PC, in-flight tracking and buffer pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
    end else if (redirect_valid) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      inflight_q    <= imem_rd;
      inflight_pc_q <= target;
      pc_q          <= imem_rd ? target + 32'd4 : target;
    end else begin
      if (push) tail_q <= ptr_next(tail_q);
      if (pop)  head_q <= ptr_next(head_q);
      count_q <= count_q + CW'(push) - CW'(pop);
      if (imem_rd) begin
        pc_q          <= pc_q + 32'd4;
        inflight_q    <= 1'b1;
        inflight_pc_q <= pc_q;
      end else begin
        inflight_q    <= 1'b0;
      end
    end
  end

  // Buffer storage: the returning word lands at the tail unless squashed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_instr[i] <= '0;
        buf_pc[i]    <= '0;
      end
    end else if (push) begin
      buf_instr[tail_q] <= imem_instr;
      buf_pc[tail_q]    <= inflight_pc_q;
    end
  end

endmodule
